// File: rtl/bank_occupancy_ctrl.sv
// bank_occupancy_ctrl: saturating occupancy counter with peak tracking, status and sticky error flags.
// Define OCC_EDGE_DETECT_EN to count sensor rising edges instead of high levels.
module bank_occupancy_ctrl #(
  parameter int CAP      = 7,
  parameter int W        = 4,
  parameter int AF_LEVEL = CAP - 1
) (
  input  logic         clkup,
  input  logic         reset,
  input  logic         up,
  input  logic         down,
  input  logic         clr,
  output logic [W-1:0] pcount,
  output logic [W-1:0] peak_count,
  output logic         full_flag,
  output logic         empty_flag,
  output logic         almost_full,
  output logic         overflow_err,
  output logic         underflow_err
);
  localparam logic [W-1:0] CAP_V = W'(CAP);
  localparam logic [W-1:0] AF_V  = W'(AF_LEVEL);
  logic         inc, dec, add, sub;
  logic [W-1:0] pcount_d, pcount_q, peak_d, peak_q;
  logic         full_d, full_q, empty_d, empty_q, af_d, af_q;
  logic         ovf_d, ovf_q, unf_d, unf_q;
`ifdef OCC_EDGE_DETECT_EN
  logic up_d_q, down_d_q;
  assign inc = up & ~up_d_q;
  assign dec = down & ~down_d_q;
  // History powers up high so a sensor already asserted at reset release is not an event.
  always_ff @(posedge clkup or posedge reset)
    if (reset) begin
      up_d_q   <= 1'b1;
      down_d_q <= 1'b1;
    end else begin
      up_d_q   <= up;
      down_d_q <= down;
    end
`else
  assign inc = up;
  assign dec = down;
`endif
  always_comb begin
    add      = inc & ~dec;
    sub      = dec & ~inc;
    pcount_d = clr ? '0 :
               (add && pcount_q != CAP_V) ? pcount_q + W'(1) :
               (sub && pcount_q != '0)    ? pcount_q - W'(1) : pcount_q;
    peak_d   = clr ? '0 : (pcount_d > peak_q ? pcount_d : peak_q);
    full_d   = pcount_d == CAP_V;
    empty_d  = pcount_d == '0;
    af_d     = pcount_d >= AF_V;
    ovf_d    = ~clr & (ovf_q | (add && pcount_q == CAP_V));
    unf_d    = ~clr & (unf_q | (sub && pcount_q == '0));
  end
  always_ff @(posedge clkup or posedge reset)
    if (reset) begin
      pcount_q <= '0;
      peak_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pcount_q <= pcount_d;
      peak_q   <= peak_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  assign pcount        = pcount_q;
  assign peak_count    = peak_q;
  assign full_flag     = full_q;
  assign empty_flag    = empty_q;
  assign almost_full   = af_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
endmodule
